// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: exception / eret commit sequencer.
//   Accepts a prioritised M-stage exception (excepttypeM/newpcM), latches the
//   faulting context, pulses the CP0 update strobes once, holds the pipeline
//   flush, waits for any outstanding I-side AXI fetch to drain, and then offers
//   the redirect PC to fetch over a valid/ready handshake.
// Ports:
//   clk, resetn                    clock, async active-low reset
//   excepttypeM/newpcM/pcM         exception type, target PC, M-stage PC
//   is_in_delayslotM/bad_addrM     delay-slot flag, faulting address
//   stallM                         M frozen; exception not accepted
//   inst_busy                      I-side fetch outstanding
//   fetch_ready                    fetch accepts the redirect
//   flush                          flush F..W
//   pc_redirect_valid/pc_redirect  redirect handshake to fetch
//   cp0_*                          CP0 strobes and data (data held from latches)
//   busy                           not IDLE
//   except_cnt                     saturating count of exceptions (eret excluded)
module exc_commit_ctrl #(
  parameter int          CNT_W     = 16,
  parameter logic [31:0] DS_OFFSET = 32'd4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      excepttypeM,
  input  logic [31:0]      newpcM,
  input  logic [31:0]      pcM,
  input  logic             is_in_delayslotM,
  input  logic [31:0]      bad_addrM,
  input  logic             stallM,
  input  logic             inst_busy,
  input  logic             fetch_ready,
  output logic             flush,
  output logic             pc_redirect_valid,
  output logic [31:0]      pc_redirect,
  output logic             cp0_exc_we,
  output logic [4:0]       cp0_exc_code,
  output logic [31:0]      cp0_epc,
  output logic             cp0_bd,
  output logic             cp0_badvaddr_we,
  output logic [31:0]      cp0_badvaddr,
  output logic             cp0_eret_we,
  output logic             busy,
  output logic [CNT_W-1:0] except_cnt
);

  typedef enum logic [1:0] {IDLE, COMMIT, WAIT_FETCH, REDIRECT} state_e;

  localparam logic [4:0] T_INT  = 5'h01;
  localparam logic [4:0] T_ADEL = 5'h04;
  localparam logic [4:0] T_ADES = 5'h05;
  localparam logic [4:0] T_ERET = 5'h0e;

  state_e             state_q, state_d;
  logic [4:0]         type_q;
  logic [4:0]         code_q;
  logic [31:0]        newpc_q, epc_q, badaddr_q;
  logic               bd_q, flush_q;
  logic [CNT_W-1:0]   cnt_q;

  // Only the listed encodings are real exceptions; anything else is ignored.
  logic type_ok;
  always_comb begin
    type_ok = 1'b0;
    case (excepttypeM)
      32'h01, 32'h04, 32'h05, 32'h08, 32'h09,
      32'h0a, 32'h0c, 32'h0e: type_ok = 1'b1;
      default:                type_ok = 1'b0;
    endcase
  end

  logic accept;
  assign accept = (state_q == IDLE) && !stallM && type_ok;

  logic is_eret_q, is_addr_q;
  assign is_eret_q = (type_q == T_ERET);
  assign is_addr_q = (type_q == T_ADEL) || (type_q == T_ADES);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (accept)      state_d = COMMIT;
      COMMIT:     state_d = inst_busy ? WAIT_FETCH : REDIRECT;
      WAIT_FETCH: if (!inst_busy)  state_d = REDIRECT;
      REDIRECT:   if (fetch_ready) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Output logic: strobes decode the current state, data comes from latches.
  always_comb begin
    flush             = flush_q;
    pc_redirect_valid = (state_q == REDIRECT);
    pc_redirect       = newpc_q;
    cp0_exc_we        = (state_q == COMMIT) && !is_eret_q;
    cp0_badvaddr_we   = (state_q == COMMIT) && is_addr_q;
    cp0_eret_we       = (state_q == COMMIT) && is_eret_q;
    cp0_exc_code      = code_q;
    cp0_epc           = epc_q;
    cp0_bd            = bd_q;
    cp0_badvaddr      = badaddr_q;
    busy              = (state_q != IDLE);
    except_cnt        = cnt_q;
  end

  // Context latches. EPC/BD/code are only rewritten by a real exception and
  // BadVAddr only by an address error, so each holds its last written value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      type_q    <= '0;
      code_q    <= '0;
      newpc_q   <= '0;
      epc_q     <= '0;
      bd_q      <= 1'b0;
      badaddr_q <= '0;
      flush_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      flush_q <= (state_d != IDLE);
      if (accept) begin
        type_q  <= excepttypeM[4:0];
        newpc_q <= newpcM;
        if (excepttypeM[4:0] != T_ERET) begin
          code_q <= (excepttypeM[4:0] == T_INT) ? 5'd0 : excepttypeM[4:0];
          epc_q  <= is_in_delayslotM ? (pcM - DS_OFFSET) : pcM;
          bd_q   <= is_in_delayslotM;
        end
        if (excepttypeM[4:0] == T_ADEL || excepttypeM[4:0] == T_ADES)
          badaddr_q <= bad_addrM;
      end
      if (state_q == COMMIT && !is_eret_q && cnt_q != {CNT_W{1'b1}})
        cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
module tb_exc_commit_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] excepttypeM = '0, newpcM = '0, pcM = '0, bad_addrM = '0;
  logic        is_in_delayslotM = 1'b0, stallM = 1'b0, inst_busy = 1'b0, fetch_ready = 1'b1;

  logic        flush, pc_redirect_valid, cp0_exc_we, cp0_bd, cp0_badvaddr_we, cp0_eret_we, busy;
  logic [31:0] pc_redirect, cp0_epc, cp0_badvaddr;
  logic [4:0]  cp0_exc_code;
  logic [15:0] except_cnt;

  logic        d2_flush, d2_valid, d2_exc_we, d2_bd, d2_bv_we, d2_eret_we, d2_busy;
  logic [31:0] d2_pc, d2_epc, d2_bv;
  logic [4:0]  d2_code;
  logic [1:0]  d2_cnt;

  always #5 clk = ~clk;

  exc_commit_ctrl dut (
    .clk(clk), .resetn(resetn), .excepttypeM(excepttypeM), .newpcM(newpcM), .pcM(pcM),
    .is_in_delayslotM(is_in_delayslotM), .bad_addrM(bad_addrM), .stallM(stallM),
    .inst_busy(inst_busy), .fetch_ready(fetch_ready), .flush(flush),
    .pc_redirect_valid(pc_redirect_valid), .pc_redirect(pc_redirect),
    .cp0_exc_we(cp0_exc_we), .cp0_exc_code(cp0_exc_code), .cp0_epc(cp0_epc), .cp0_bd(cp0_bd),
    .cp0_badvaddr_we(cp0_badvaddr_we), .cp0_badvaddr(cp0_badvaddr), .cp0_eret_we(cp0_eret_we),
    .busy(busy), .except_cnt(except_cnt));

  // Narrow-counter instance for the saturation check; shares all inputs.
  exc_commit_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .resetn(resetn), .excepttypeM(excepttypeM), .newpcM(newpcM), .pcM(pcM),
    .is_in_delayslotM(is_in_delayslotM), .bad_addrM(bad_addrM), .stallM(stallM),
    .inst_busy(inst_busy), .fetch_ready(fetch_ready), .flush(d2_flush),
    .pc_redirect_valid(d2_valid), .pc_redirect(d2_pc),
    .cp0_exc_we(d2_exc_we), .cp0_exc_code(d2_code), .cp0_epc(d2_epc), .cp0_bd(d2_bd),
    .cp0_badvaddr_we(d2_bv_we), .cp0_badvaddr(d2_bv), .cp0_eret_we(d2_eret_we),
    .busy(d2_busy), .except_cnt(d2_cnt));

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [31:0] typ;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] newpc;
    logic [31:0] bad;
    logic        acc;
    logic        eret;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bv_we;
  } vec_t;

  typedef struct {
    logic        eret;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic        bv_we;
    logic [31:0] bv;
    logic [31:0] newpc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] redir_exp = '0;
  int          cnt_model = 0;

  // Scoreboard: pop the expected record when the CP0 strobes fire, and check
  // the redirect PC on the handshake cycle.
  always @(negedge clk) begin
    if (resetn) begin
      if (cp0_exc_we || cp0_eret_we) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_strobe", {cp0_exc_we, cp0_eret_we}, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_eret_we", cp0_eret_we, e.eret);
          chk("sb_exc_we", cp0_exc_we, !e.eret);
          chk("sb_bv_we", cp0_badvaddr_we, e.bv_we);
          chk("sb_flush", flush, 1);
          if (!e.eret) begin
            chk("sb_code", cp0_exc_code, e.code);
            chk("sb_epc", cp0_epc, e.epc);
            chk("sb_bd", cp0_bd, e.bd);
          end
          if (e.bv_we) chk("sb_badvaddr", cp0_badvaddr, e.bv);
          redir_exp = e.newpc;
        end
      end
      if (pc_redirect_valid && fetch_ready) chk("sb_redirect", pc_redirect, redir_exp);
    end
  end

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.eret = v.eret; e.code = v.code; e.epc = v.epc; e.bd = v.ds;
    e.bv_we = v.bv_we; e.bv = v.bad; e.newpc = v.newpc;
    sb_q.push_back(e);
  endtask

  task automatic drive(input vec_t v);
    excepttypeM = v.typ; pcM = v.pc; is_in_delayslotM = v.ds;
    newpcM = v.newpc; bad_addrM = v.bad;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    logic first_busy;
    @(posedge clk); #1;
    drive(v); stallM = 0;
    if (v.acc) push_exp(v);
    @(posedge clk); #1;
    excepttypeM = '0;
    @(negedge clk);
    first_busy = busy;
    n = 1;
    while (busy && n < 50) begin @(negedge clk); n++; end
    chk("accepted", first_busy, v.acc);
    chk("idle_timeout", busy, 0);
    if (v.acc && !v.eret) cnt_model++;
    chk("except_cnt", except_cnt, cnt_model);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 0;
    #3;
    resetn = 1;
    cnt_model = 0;
    sb_q.delete();
  endtask

  vec_t vt[10];
  vec_t v;

  initial begin
    vt[0] = '{32'h8, 32'hbfc00100, 0, 32'hbfc00380, 32'h0, 1, 0, 5'd8,  32'hbfc00100, 0};
    vt[1] = '{32'h4, 32'hbfc00204, 1, 32'hbfc00380, 32'h3, 1, 0, 5'd4,  32'hbfc00200, 1};
    vt[2] = '{32'h5, 32'h80000010, 0, 32'hbfc00380, 32'h1235, 1, 0, 5'd5, 32'h80000010, 1};
    vt[3] = '{32'h9, 32'h00000000, 1, 32'hbfc00380, 32'h0, 1, 0, 5'd9,  32'hfffffffc, 0};
    vt[4] = '{32'ha, 32'h00400020, 0, 32'hbfc00380, 32'h0, 1, 0, 5'd10, 32'h00400020, 0};
    vt[5] = '{32'hc, 32'h00400044, 1, 32'hbfc00380, 32'h0, 1, 0, 5'd12, 32'h00400040, 0};
    vt[6] = '{32'he, 32'h00400050, 0, 32'hbfc00120, 32'h0, 1, 1, 5'd0,  32'h0, 0};
    vt[7] = '{32'h1, 32'h00400060, 0, 32'hbfc00380, 32'h0, 1, 0, 5'd0,  32'h00400060, 0};
    vt[8] = '{32'h2, 32'h00400070, 0, 32'hbfc00380, 32'h0, 0, 0, 5'd0,  32'h0, 0};
    vt[9] = '{32'h1f, 32'h00400080, 0, 32'hbfc00380, 32'h0, 0, 0, 5'd0, 32'h0, 0};

    // Reset state
    #2;
    chk("rst_ctrl", {flush, pc_redirect_valid, cp0_exc_we, cp0_badvaddr_we, cp0_eret_we, busy, cp0_bd, cp0_exc_code}, 0);
    chk("rst_cnt", except_cnt, 0);
    #5 resetn = 1;

    // Syscall with exact cycle timing
    @(posedge clk); #1;
    drive(vt[0]); push_exp(vt[0]);
    @(posedge clk); #1; excepttypeM = '0;
    @(negedge clk);
    chk("T1_flush", flush, 1);
    chk("T1_exc_we", cp0_exc_we, 1);
    chk("T1_valid", pc_redirect_valid, 0);
    @(negedge clk);
    chk("T2_valid", pc_redirect_valid, 1);
    chk("T2_pc", pc_redirect, 32'hbfc00380);
    chk("T2_exc_we", cp0_exc_we, 0);
    chk("T2_flush", flush, 1);
    @(negedge clk);
    chk("T3_busy", busy, 0);
    chk("T3_flush_valid", {flush, pc_redirect_valid}, 0);
    cnt_model = 1;
    chk("T3_cnt", except_cnt, 1);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    // Interrupt under stall, then I-side drain and slow fetch
    v = vt[7]; v.pc = 32'h00401000; v.epc = 32'h00401000; v.newpc = 32'hbfc00388;
    @(posedge clk); #1;
    drive(v); stallM = 1; inst_busy = 1; push_exp(v);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_no_accept", busy, 0);
    end
    #1 stallM = 0;
    @(posedge clk); #1; excepttypeM = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wait_fetch_flush_valid", {flush, pc_redirect_valid}, 2'b10);
    end
    #1 inst_busy = 0; fetch_ready = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("redir_hold_valid", pc_redirect_valid, 1);
      chk("redir_hold_pc", pc_redirect, 32'hbfc00388);
    end
    #1 fetch_ready = 1;
    @(negedge clk);
    chk("after_hs_busy", {busy, flush, pc_redirect_valid}, 0);
    cnt_model++;
    chk("stall_cnt", except_cnt, cnt_model);

    // Reset asserted while REDIRECT is being offered
    fetch_ready = 0;
    @(posedge clk); #1;
    drive(vt[0]); push_exp(vt[0]);
    @(posedge clk); #1; excepttypeM = '0;
    begin
      int n = 0;
      while (!pc_redirect_valid && n < 20) begin @(negedge clk); n++; end
      chk("reach_redirect", pc_redirect_valid, 1);
    end
    #1 resetn = 0;
    #1;
    chk("arst_ctrl", {flush, pc_redirect_valid, cp0_exc_we, cp0_badvaddr_we, cp0_eret_we, busy, cp0_bd, cp0_exc_code}, 0);
    chk("arst_pc", pc_redirect, 0);
    chk("arst_epc", cp0_epc, 0);
    chk("arst_cnt", except_cnt, 0);
    fetch_ready = 1;
    sb_q.delete();
    cnt_model = 0;
    #2 resetn = 1;
    @(negedge clk);
    chk("post_rst_idle", busy, 0);
    run_vec(vt[1]);

    // Saturating counter on the CNT_W=2 instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_vec(vt[0]);
      chk("sat_cnt", d2_cnt, (i < 3) ? i + 1 : 3);
    end

    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
